// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave memory bus arbiter.
// Master 0 (CPU) and master 1 (UART bootloader/DMA) share one RAM/IO slave.
// Round-robin arbitration with one transaction outstanding; a slave-ack
// timeout aborts hung transactions with an error so the bus never locks up.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   mX_req/we/addr/wdata/wmask master X command, held until mX_done
//   mX_done/err/rdata          one-cycle completion pulse, error flag, read data
//   s_req/we/addr/wdata/wmask  slave command; s_* qualified only by s_req
//   s_ack/s_rdata              slave completion and read data
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_done,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_done,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              s_req_q, s_req_d;
    logic              s_we_q, s_we_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [MASK_W-1:0] s_wmask_q, s_wmask_d;

    logic              m0_done_q, m0_done_d;
    logic              m0_err_q, m0_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic              m1_done_q, m1_done_d;
    logic              m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              win_c;
    logic              fin_c;
    logic              fin_err_c;
    logic [DATA_W-1:0] fin_rdata_c;

    // Next-state and datapath logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wmask_d    = s_wmask_q;
        m0_done_d    = 1'b0;
        m0_err_d     = m0_err_q;
        m0_rdata_d   = m0_rdata_q;
        m1_done_d    = 1'b0;
        m1_err_d     = m1_err_q;
        m1_rdata_d   = m1_rdata_q;
        win_c        = 1'b0;
        fin_c        = 1'b0;
        fin_err_c    = 1'b0;
        fin_rdata_c  = '0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the master that was not served last wins
                if (m0_req && m1_req) begin
                    win_c = ~last_grant_q;
                end else begin
                    win_c = m1_req;
                end
                if (m0_req || m1_req) begin
                    grant_d      = win_c;
                    last_grant_d = win_c;
                    cnt_d        = '0;
                    s_req_d      = 1'b1;
                    s_we_d       = win_c ? m1_we    : m0_we;
                    s_addr_d     = win_c ? m1_addr  : m0_addr;
                    s_wdata_d    = win_c ? m1_wdata : m0_wdata;
                    s_wmask_d    = win_c ? m1_wmask : m0_wmask;
                    state_d      = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // Saturating count so an oversized wait never wraps
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // Ack takes priority over a coincident timeout
                if (s_ack) begin
                    fin_c       = 1'b1;
                    fin_err_c   = 1'b0;
                    fin_rdata_c = s_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    fin_c       = 1'b1;
                    fin_err_c   = 1'b1;
                    fin_rdata_c = '0;
                end
                if (fin_c) begin
                    s_req_d = 1'b0;
                    state_d = ST_DONE;
                    if (grant_q) begin
                        m1_done_d  = 1'b1;
                        m1_err_d   = fin_err_c;
                        m1_rdata_d = fin_rdata_c;
                    end else begin
                        m0_done_d  = 1'b1;
                        m0_err_d   = fin_err_c;
                        m0_rdata_d = fin_rdata_c;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wmask_q    <= '0;
            m0_done_q    <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_done_q    <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wmask_q    <= s_wmask_d;
            m0_done_q    <= m0_done_d;
            m0_err_q     <= m0_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_done_q    <= m1_done_d;
            m1_err_q     <= m1_err_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wmask  = s_wmask_q;
    assign m0_done  = m0_done_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_done  = m1_done_q;
    assign m1_err   = m1_err_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
// (TIMEOUT=8). Inputs change and outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MASK_W  = DATA_W / 8;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_we, m0_done, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic [MASK_W-1:0] m0_wmask;
    logic              m1_req, m1_we, m1_done, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [MASK_W-1:0] m1_wmask;
    logic              s_req, s_we, s_ack;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, s_rdata;
    logic [MASK_W-1:0] s_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_req  (m0_req),
        .m0_we   (m0_we),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask),
        .m0_done (m0_done),
        .m0_err  (m0_err),
        .m0_rdata(m0_rdata),
        .m1_req  (m1_req),
        .m1_we   (m1_we),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask),
        .m1_done (m1_done),
        .m1_err  (m1_err),
        .m1_rdata(m1_rdata),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wmask (s_wmask),
        .s_ack   (s_ack),
        .s_rdata (s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until s_req rises, bounded
    task automatic wait_sreq(input string tag);
        int k = 0;
        step();
        while (s_req !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        chk(tag, 32'(s_req), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        s_ack = 1'b0; s_rdata = '0;
        step();
        step();

        // Reset values
        chk("rst_s_req",    32'(s_req),    32'd0);
        chk("rst_s_addr",   32'(s_addr),   32'd0);
        chk("rst_m0_done",  32'(m0_done),  32'd0);
        chk("rst_m1_done",  32'(m1_done),  32'd0);
        chk("rst_m0_rdata", m0_rdata,      32'd0);
        reset = 1'b0;

        // Tie after reset: both hold req for 6 transactions, grants 0,1,0,1,0,1
        m0_addr = 24'h000100; m1_addr = 24'h000200;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_sreq($sformatf("tie%0d_sreq", i));
            chk($sformatf("tie%0d_addr", i), 32'(s_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
            s_ack = 1'b1; s_rdata = 32'(i + 16);
            step();
            s_ack = 1'b0;
            chk($sformatf("tie%0d_m0_done", i), 32'(m0_done), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("tie%0d_m1_done", i), 32'(m1_done), (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("tie%0d_rdata", i), (i % 2 == 0) ? m0_rdata : m1_rdata, 32'(i + 16));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        // Single read from m0, zero-wait slave
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 24'h000010;
        step();
        chk("rd_sreq", 32'(s_req), 32'd1);
        chk("rd_addr", 32'(s_addr), 32'h10);
        chk("rd_we",   32'(s_we),   32'd0);
        s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
        step();
        s_ack = 1'b0; m0_req = 1'b0;
        chk("rd_done",    32'(m0_done), 32'd1);
        chk("rd_rdata",   m0_rdata,     32'hDEADBEEF);
        chk("rd_err",     32'(m0_err),  32'd0);
        chk("rd_m1_done", 32'(m1_done), 32'd0);
        chk("rd_sreq_lo", 32'(s_req),   32'd0);
        step();
        chk("rd_done_1cyc", 32'(m0_done), 32'd0);
        chk("rd_rdata_hold", m0_rdata,    32'hDEADBEEF);

        // m1 write with 5-cycle slave
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 24'h000100;
        m1_wdata = 32'h12345678; m1_wmask = 4'b0011;
        s_rdata = '0;
        step();
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("wr_c%0d_sreq", c),  32'(s_req),   32'd1);
            chk($sformatf("wr_c%0d_we", c),    32'(s_we),    32'd1);
            chk($sformatf("wr_c%0d_wmask", c), 32'(s_wmask), 32'h3);
            chk($sformatf("wr_c%0d_done", c),  32'(m1_done), 32'd0);
            if (c == 5) s_ack = 1'b1;
            step();
        end
        s_ack = 1'b0; m1_req = 1'b0;
        chk("wr_addr",  32'(s_addr),  32'h100);
        chk("wr_wdata", s_wdata,      32'h12345678);
        chk("wr_done",  32'(m1_done), 32'd1);
        chk("wr_err",   32'(m1_err),  32'd0);
        chk("wr_m0_done", 32'(m0_done), 32'd0);
        step();

        // Timeout: slave never acks, s_req high exactly 8 cycles
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 24'h000020;
        step();
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("to_c%0d_sreq", c), 32'(s_req),   32'd1);
            chk($sformatf("to_c%0d_done", c), 32'(m0_done), 32'd0);
            step();
        end
        m0_req = 1'b0;
        chk("to_sreq_lo", 32'(s_req),   32'd0);
        chk("to_done",    32'(m0_done), 32'd1);
        chk("to_err",     32'(m0_err),  32'd1);
        chk("to_rdata",   m0_rdata,     32'd0);
        step();

        // Following request served normally
        m0_req = 1'b1; m0_addr = 24'h000030;
        step();
        chk("post_to_sreq", 32'(s_req), 32'd1);
        s_ack = 1'b1; s_rdata = 32'h00000055;
        step();
        s_ack = 1'b0; m0_req = 1'b0;
        chk("post_to_done",  32'(m0_done), 32'd1);
        chk("post_to_err",   32'(m0_err),  32'd0);
        chk("post_to_rdata", m0_rdata,     32'h55);
        step();

        // Ack on the 8th BUSY cycle wins over the timeout
        m0_req = 1'b1;
        step();
        for (int c = 1; c <= 7; c++) step();
        chk("aot_sreq", 32'(s_req), 32'd1);
        s_ack = 1'b1; s_rdata = 32'hA5A5A5A5;
        step();
        s_ack = 1'b0; m0_req = 1'b0;
        chk("aot_done",  32'(m0_done), 32'd1);
        chk("aot_err",   32'(m0_err),  32'd0);
        chk("aot_rdata", m0_rdata,     32'hA5A5A5A5);
        step();

        // Reset mid-BUSY on an m0 transaction
        m0_req = 1'b1; m0_addr = 24'h000040;
        step();
        chk("rmb_sreq", 32'(s_req), 32'd1);
        m0_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmb_sreq_lo", 32'(s_req),   32'd0);
        chk("rmb_no_done", 32'(m0_done), 32'd0);
        chk("rmb_rdata",   m0_rdata,     32'd0);
        s_ack = 1'b1; s_rdata = 32'h00000BAD;
        step();
        s_ack = 1'b0;
        chk("rmb_late_ack_done0", 32'(m0_done), 32'd0);
        chk("rmb_late_ack_done1", 32'(m1_done), 32'd0);
        chk("rmb_late_ack_sreq",  32'(s_req),   32'd0);
        step();
        chk("rmb_late_ack_rdata", m0_rdata, 32'd0);

        // Tie after reset grants m0
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        chk("rmb_tie_sreq", 32'(s_req),  32'd1);
        chk("rmb_tie_addr", 32'(s_addr), 32'h40);
        s_ack = 1'b1; s_rdata = 32'h0000CAFE;
        step();
        s_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        chk("rmb_tie_m0_done", 32'(m0_done), 32'd1);
        chk("rmb_tie_m1_done", 32'(m1_done), 32'd0);
        chk("rmb_tie_rdata",   m0_rdata,     32'hCAFE);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
